// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path.
//   SEG_* : active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   DIG_* : scan slot index of each displayed digit
//   MAX_* : largest legal time-of-day field values
//   to_bcd: splits a 0..59 binary value into tens/ones nibbles
package clock_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [2:0] DIG_SEC_ONES = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS = 3'd3;
  localparam logic [2:0] DIG_HR_ONES  = 3'd4;
  localparam logic [2:0] DIG_HR_TENS  = 3'd5;

  localparam logic [4:0] MAX_HOURS   = 5'd23;
  localparam logic [5:0] MAX_MIN_SEC = 6'd59;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } tod_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Compare/subtract chain: a single priority ladder is enough because
  // inputs never exceed 59, so tens never exceeds 5.
  function automatic bcd_t to_bcd(input logic [5:0] value);
    bcd_t       r;
    logic [5:0] rem;
    if (value >= 6'd50) begin
      r.tens = 4'd5;
      rem    = value - 6'd50;
    end else if (value >= 6'd40) begin
      r.tens = 4'd4;
      rem    = value - 6'd40;
    end else if (value >= 6'd30) begin
      r.tens = 4'd3;
      rem    = value - 6'd30;
    end else if (value >= 6'd20) begin
      r.tens = 4'd2;
      rem    = value - 6'd20;
    end else if (value >= 6'd10) begin
      r.tens = 4'd1;
      rem    = value - 6'd10;
    end else begin
      r.tens = 4'd0;
      rem    = value;
    end
    r.ones = rem[3:0];
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder with output polarity select.
//   bcd : 4-bit BCD digit; codes above 9 decode to all segments unlit
//   seg : segment drive {g,f,e,d,c,b,a}, polarity set by ACT_LOW
module seg7_decode
  import clock_pkg::*;
#(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_OFF;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_OFF;
    endcase
  end

  assign seg = ACT_LOW ? ~pattern : pattern;

endmodule

// File: rtl/clock_display_driver.sv
// Drives a 6-digit multiplexed 7-segment display (HH.MM.SS) from the
// binary time-of-day of the clock core.
//   clk, reset        : system clock, asynchronous active-high reset
//   hours/minutes/seconds, time_valid : time strobe from the clock core
//   enable            : 0 blanks all anodes, scan keeps running
//   seg, dp, an       : registered display pins (polarity per parameters)
//   range_err         : sticky flag, a strobe carried an illegal value
// A new time is held as "pending" and only copied to the shown value at
// the end of a full 6-digit frame, so a frame never mixes two times.
module clock_display_driver
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          AN_ACT_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       time_valid,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       range_err
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [6:0] SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [5:0] AN_IDLE  = AN_ACT_LOW ? 6'h3F : 6'h00;

  tod_t             pending_reg;
  logic             pending_valid_reg;
  tod_t             shown_reg;
  logic             range_err_reg;
  logic [PRE_W-1:0] prescaler_reg;
  logic [2:0]       digit_idx_reg;

  logic [6:0] seg_reg;
  logic       dp_reg;
  logic [5:0] an_reg;

  logic slot_end;
  logic frame_end;
  logic in_range;

  assign slot_end  = (prescaler_reg == PRE_LAST);
  assign frame_end = slot_end && (digit_idx_reg == DIG_HR_TENS);
  assign in_range  = (hours <= MAX_HOURS) && (minutes <= MAX_MIN_SEC) &&
                     (seconds <= MAX_MIN_SEC);

  // Capture, pending hand-off and sticky range error. On a boundary cycle
  // the old pending value moves to shown while a simultaneous strobe
  // refills pending, so the new value waits for the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      shown_reg         <= '0;
      range_err_reg     <= 1'b0;
    end else begin
      if (frame_end && pending_valid_reg) begin
        shown_reg <= pending_reg;
      end
      if (time_valid && in_range) begin
        pending_reg       <= '{hours: hours, minutes: minutes, seconds: seconds};
        pending_valid_reg <= 1'b1;
      end else if (frame_end) begin
        pending_valid_reg <= 1'b0;
      end
      if (time_valid && !in_range) begin
        range_err_reg <= 1'b1;
      end
    end
  end

  // Free-running scan timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_reg <= '0;
      digit_idx_reg <= DIG_SEC_ONES;
    end else if (slot_end) begin
      prescaler_reg <= '0;
      digit_idx_reg <= (digit_idx_reg == DIG_HR_TENS) ? DIG_SEC_ONES
                                                      : digit_idx_reg + 3'd1;
    end else begin
      prescaler_reg <= prescaler_reg + 1'b1;
    end
  end

  bcd_t sec_bcd;
  bcd_t min_bcd;
  bcd_t hr_bcd;

  assign sec_bcd = to_bcd(shown_reg.seconds);
  assign min_bcd = to_bcd(shown_reg.minutes);
  assign hr_bcd  = to_bcd({1'b0, shown_reg.hours});

  logic [3:0] digit_bcd;

  always_comb begin
    digit_bcd = 4'hF;
    case (digit_idx_reg)
      DIG_SEC_ONES: digit_bcd = sec_bcd.ones;
      DIG_SEC_TENS: digit_bcd = sec_bcd.tens;
      DIG_MIN_ONES: digit_bcd = min_bcd.ones;
      DIG_MIN_TENS: digit_bcd = min_bcd.tens;
      DIG_HR_ONES:  digit_bcd = hr_bcd.ones;
      DIG_HR_TENS:  digit_bcd = hr_bcd.tens;
      default:      digit_bcd = 4'hF;
    endcase
  end

  logic [6:0] seg_next;

  seg7_decode #(
    .ACT_LOW(SEG_ACT_LOW)
  ) u_seg7_decode (
    .bcd(digit_bcd),
    .seg(seg_next)
  );

  // Anodes are dark during the first BLANK_CYCLES of each slot so the
  // previous digit's segments cannot ghost onto the newly selected digit.
  logic       an_active;
  logic [5:0] an_hot;
  logic [5:0] an_next;
  logic       dp_lit;
  logic       dp_next;

  assign an_active = enable && (prescaler_reg >= PRE_BLANK);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_an
      assign an_hot[gi] = an_active && (digit_idx_reg == 3'(gi));
    end
  endgenerate

  assign an_next = AN_ACT_LOW ? ~an_hot : an_hot;

  // Separators after the minutes and hours ones digits blink with seconds.
  assign dp_lit  = ((digit_idx_reg == DIG_MIN_ONES) || (digit_idx_reg == DIG_HR_ONES)) &&
                   !shown_reg.seconds[0];
  assign dp_next = SEG_ACT_LOW ? ~dp_lit : dp_lit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_reg <= SEG_IDLE;
      dp_reg  <= SEG_ACT_LOW;
      an_reg  <= AN_IDLE;
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign an        = an_reg;
  assign range_err = range_err_reg;

endmodule

// File: tb/tb_clock_display_driver.sv
module tb_clock_display_driver;

  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;

  logic       clk;
  logic       reset;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       time_valid;
  logic       enable;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       range_err;

  clock_display_driver #(
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK),
    .SEG_ACT_LOW(1'b1),
    .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hours(hours),
    .minutes(minutes),
    .seconds(seconds),
    .time_valid(time_valid),
    .enable(enable),
    .seg(seg),
    .dp(dp),
    .an(an),
    .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       rerr;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int m_pre, m_idx;
  int m_sh_h, m_sh_m, m_sh_s;
  int m_pd_h, m_pd_m, m_pd_s;
  bit m_pv, m_rerr;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_idx = 0;
    m_sh_h = 0; m_sh_m = 0; m_sh_s = 0;
    m_pd_h = 0; m_pd_m = 0; m_pd_s = 0;
    m_pv = 0; m_rerr = 0;
  endtask

  // Predict the outputs registered at the coming edge, advance the model,
  // then compare against the DUT just after that edge.
  task automatic tick();
    exp_t       e;
    exp_t       got_e;
    int         digit;
    logic [5:0] onehot;
    bit         boundary;
    digit = 0;
    case (m_idx)
      0: digit = m_sh_s % 10;
      1: digit = m_sh_s / 10;
      2: digit = m_sh_m % 10;
      3: digit = m_sh_m / 10;
      4: digit = m_sh_h % 10;
      default: digit = m_sh_h / 10;
    endcase
    e.seg  = seg_of(digit);
    e.dp   = ((m_idx == 2 || m_idx == 4) && (m_sh_s % 2 == 0)) ? 1'b0 : 1'b1;
    onehot = 6'd1 << m_idx;
    e.an   = (enable && m_pre >= BLANK) ? ~onehot : 6'h3F;

    boundary = (m_pre == SCAN_DIV - 1) && (m_idx == 5);
    if (boundary && m_pv) begin
      m_sh_h = m_pd_h; m_sh_m = m_pd_m; m_sh_s = m_pd_s;
      m_pv = 0;
    end
    if (time_valid) begin
      if (hours <= 23 && minutes <= 59 && seconds <= 59) begin
        m_pd_h = hours; m_pd_m = minutes; m_pd_s = seconds;
        m_pv = 1;
      end else begin
        m_rerr = 1;
      end
    end
    e.rerr = m_rerr;
    if (m_pre == SCAN_DIV - 1) begin
      m_pre = 0;
      m_idx = (m_idx == 5) ? 0 : m_idx + 1;
    end else begin
      m_pre++;
    end
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      $display("cyc %0d: an=%b seg=%b dp=%b rerr=%b (exp an=%b seg=%b dp=%b rerr=%b)",
               cyc, an, seg, dp, range_err, got_e.an, got_e.seg, got_e.dp, got_e.rerr);
      check("an", 32'(an), 32'(got_e.an));
      check("seg", 32'(seg), 32'(got_e.seg));
      check("dp", 32'(dp), 32'(got_e.dp));
      check("range_err", 32'(range_err), 32'(got_e.rerr));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int h, input int m, input int s);
    hours      = 5'(h);
    minutes    = 6'(m);
    seconds    = 6'(s);
    time_valid = 1'b1;
    tick();
    time_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 32'(an), 32'h3F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_rerr"}, 32'(range_err), 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    time_valid = 1'b0;
    hours      = '0;
    minutes    = '0;
    seconds    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Idle scan of zeros
    run(30);

    // Mid-frame strobe shows only after the frame boundary
    run(5);
    strobe(13, 45, 8);
    run(60);

    // Two strobes in one frame: only the later one is ever shown
    for (int i = 0; i < 30 && m_idx != 1; i++) tick();
    strobe(23, 59, 59);
    run(3);
    strobe(0, 0, 0);
    run(50);

    // Out-of-range strobes, then a valid one
    strobe(24, 10, 10);
    run(30);
    strobe(5, 60, 0);
    run(5);
    strobe(9, 7, 6);
    run(50);

    // Strobe landing exactly on the frame boundary with a value pending
    strobe(12, 34, 56);
    run(2);
    for (int i = 0; i < 30 && !(m_pre == SCAN_DIV - 1 && m_idx == 5); i++) tick();
    check("on_boundary", 32'(m_pre == SCAN_DIV - 1 && m_idx == 5), 32'd1);
    strobe(21, 43, 7);
    run(60);

    // Display disable window
    run(2);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(20);

    // Asynchronous reset mid-slot
    run(2);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(30);
    strobe(7, 8, 9);
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
